// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: frame constants and receiver FSM states.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_OSR       = 16;
  localparam int UART_START_MID = 7;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_rx_state_e;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } uart_rx_state_e;
`endif

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick generator: one-cycle pulse every clk_rate/(baud_rate*16) cycles,
// with a synchronous clear used to phase-align to a detected start edge.
module uart_os_tick
  import uart_pkg::*;
#(
  parameter int clk_rate  = 100_000_000,
  parameter int baud_rate = 9600
) (
  input  logic uart_clk,
  input  logic uart_rst_n,
  input  logic clr,
  output logic tick
);

  localparam int OSR_DIV = clk_rate / (baud_rate * UART_OSR);
  localparam int CW      = $clog2(OSR_DIV + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(OSR_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || (cnt_q == CNT_MAX)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge uart_clk or negedge uart_rst_n) begin
    if (!uart_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_rx_core.sv
// 16x oversampling UART receiver with one-entry valid/ready output buffer.
// Define UART_RX_PARITY_EN for 8E1 frames; otherwise frames are 8N1.
//
// state  | meaning
// IDLE   | line idle, waiting for a low on the synchronized input
// START  | start edge seen, confirm low at start-bit centre
// DATA   | shifting in 8 data bits, LSB first
// PARITY | sampling the even-parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling the stop bit, then back to IDLE at its centre
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int clk_rate  = 100_000_000,
  parameter int baud_rate = 9600
) (
  input  logic       uart_clk,
  input  logic       uart_rst_n,
  input  logic       rx_in,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_parity_err,
  output logic       rx_overrun
);

  localparam logic [3:0] SAMP_LAST = 4'(UART_OSR - 1);
  localparam logic [3:0] SAMP_MID  = 4'(UART_START_MID);
  localparam logic [2:0] BIT_LAST  = 3'(UART_DATA_BITS - 1);

  uart_rx_state_e            state_q, state_d;
  logic [1:0]                sync_q, sync_d;
  logic [3:0]                samp_cnt_q, samp_cnt_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [7:0]                data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      ferr_q, ferr_d;
  logic                      ovr_q, ovr_d;
  logic                      tick, tick_clr, frame_done, rx_s;
`ifdef UART_RX_PARITY_EN
  logic                      par_bit_q, par_bit_d;
  logic                      perr_q, perr_d;
`endif

  assign sync_d = {sync_q[0], rx_in};
  assign rx_s   = sync_q[1];

  uart_os_tick #(
    .clk_rate (clk_rate),
    .baud_rate(baud_rate)
  ) u_os_tick (
    .uart_clk  (uart_clk),
    .uart_rst_n(uart_rst_n),
    .clr       (tick_clr),
    .tick      (tick)
  );

  always_comb begin
    state_d    = state_q;
    samp_cnt_d = samp_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = valid_q && !rx_ready;
    ferr_d     = 1'b0;
    ovr_d      = 1'b0;
    tick_clr   = 1'b0;
    frame_done = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d  = par_bit_q;
    perr_d     = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          tick_clr   = 1'b1;
          samp_cnt_d = 4'd0;
          state_d    = START;
        end
      end
      START: begin
        if (tick) begin
          samp_cnt_d = samp_cnt_q + 4'd1;
          if (samp_cnt_q == SAMP_MID) begin
            samp_cnt_d = 4'd0;
            bit_idx_d  = 3'd0;
            state_d    = rx_s ? IDLE : DATA;
          end
        end
      end
      DATA: begin
        if (tick) begin
          samp_cnt_d = samp_cnt_q + 4'd1;
          if (samp_cnt_q == SAMP_LAST) begin
            shift_d   = {rx_s, shift_q[UART_DATA_BITS-1:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          samp_cnt_d = samp_cnt_q + 4'd1;
          if (samp_cnt_q == SAMP_LAST) begin
            par_bit_d = rx_s;
            state_d   = STOP;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          samp_cnt_d = samp_cnt_q + 4'd1;
          if (samp_cnt_q == SAMP_LAST) begin
            frame_done = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered results appear the cycle after the stop-bit sample
    if (frame_done) begin
      if (!rx_s) begin
        ferr_d = 1'b1;
      end
`ifdef UART_RX_PARITY_EN
      else if (par_bit_q != ^shift_q) begin
        perr_d = 1'b1;
      end
`endif
      else if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge uart_clk or negedge uart_rst_n) begin
    if (!uart_rst_n) begin
      state_q    <= IDLE;
      sync_q     <= 2'b11;
      samp_cnt_q <= 4'd0;
      bit_idx_q  <= 3'd0;
      shift_q    <= '0;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q  <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      samp_cnt_q <= samp_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q  <= par_bit_d;
      perr_q     <= perr_d;
`endif
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = ferr_q;
  assign rx_overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign rx_parity_err = perr_q;
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core at 64 clocks per bit; stimulus pushes expected
// events, a negedge monitor pops and compares each byte handshake and error pulse.
module tb_uart_rx_core;
  import uart_pkg::*;

  localparam int CLK_RATE = 6_400_000;
  localparam int BAUD     = 100_000;
  localparam int CPB      = 64;

  localparam int K_DATA = 0;
  localparam int K_FERR = 1;
  localparam int K_PERR = 2;
  localparam int K_OVR  = 3;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } exp_t;

  logic       uart_clk;
  logic       uart_rst_n;
  logic       rx_in;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_parity_err;
  logic       rx_overrun;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  uart_rx_core #(
    .clk_rate (CLK_RATE),
    .baud_rate(BAUD)
  ) dut (
    .uart_clk     (uart_clk),
    .uart_rst_n   (uart_rst_n),
    .rx_in        (rx_in),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_parity_err(rx_parity_err),
    .rx_overrun   (rx_overrun)
  );

  initial uart_clk = 1'b0;
  always #5 uart_clk = ~uart_clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] d);
    exp_t e;
    e.kind = kind;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic check_evt(input int kind, input logic [7:0] d);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL sb_unexpected: got event kind %0d data 0x%0h, expected no event", kind, d);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || (kind == K_DATA && e.data != d)) begin
        fails++;
        $display("FAIL sb_event: got kind %0d data 0x%0h, expected kind %0d data 0x%0h",
                 kind, d, e.kind, e.data);
      end
    end
  endtask

  always @(negedge uart_clk) begin
    if (rx_frame_err)        check_evt(K_FERR, 8'h00);
    if (rx_parity_err)       check_evt(K_PERR, 8'h00);
    if (rx_overrun)          check_evt(K_OVR, 8'h00);
    if (rx_valid && rx_ready) check_evt(K_DATA, rx_data);
  end

  task automatic idle(input int n);
    repeat (n) @(posedge uart_clk);
    #1;
  endtask

  // bits[0] goes on the line first; last bit held for last_cycles, then line idles high
  task automatic send_raw(input logic [10:0] bits, input int nbits, input int last_cycles);
    for (int i = 0; i < nbits; i++) begin
      rx_in = bits[i];
      repeat ((i == nbits - 1) ? last_cycles : CPB) @(posedge uart_clk);
      #1;
    end
    rx_in = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input int last_cycles);
`ifdef UART_RX_PARITY_EN
    send_raw({stop_v, ^d, d, 1'b0}, 11, last_cycles);
`else
    send_raw({1'b0, stop_v, d, 1'b0}, 10, last_cycles);
`endif
  endtask

  initial begin
    uart_rst_n = 1'b0;
    rx_in      = 1'b1;
    rx_ready   = 1'b1;
    idle(3);
    chk("reset_data", int'(rx_data), 0);
    chk("reset_flags", int'({rx_valid, rx_frame_err, rx_parity_err, rx_overrun}), 0);
    uart_rst_n = 1'b1;
    idle(20);

    // clean byte with consumer always ready
    push(K_DATA, 8'hA5);
    send_frame(8'hA5, 1'b1, CPB);
    idle(CPB);

    // stop bit low: frame error, then same byte cleanly
    push(K_FERR, 8'h00);
    send_frame(8'h3C, 1'b0, 48);
    idle(2 * CPB);
    push(K_DATA, 8'h3C);
    send_frame(8'h3C, 1'b1, CPB);
    idle(CPB);

    // short glitch must be rejected as a false start
    rx_in = 1'b0;
    idle(16);
    rx_in = 1'b1;
    idle(2 * CPB);
    chk("glitch_state_idle", int'(dut.state_q), int'(IDLE));
    chk("glitch_no_valid", int'(rx_valid), 0);
    push(K_DATA, 8'h81);
    send_frame(8'h81, 1'b1, CPB);
    idle(CPB);

    // overrun: second byte dropped while first is held
    rx_ready = 1'b0;
    push(K_OVR, 8'h00);
    push(K_DATA, 8'h11);
    send_frame(8'h11, 1'b1, CPB);
    send_frame(8'h22, 1'b1, CPB);
    idle(4);
    chk("ovr_valid_held", int'(rx_valid), 1);
    chk("ovr_data_kept", int'(rx_data), 'h11);
    rx_ready = 1'b1;
    @(posedge uart_clk);
    #1;
    chk("ovr_valid_falls", int'(rx_valid), 0);
    idle(CPB);

    // reset in the middle of bit 4 of 0xF0
    rx_in = 1'b0;
    idle(5 * CPB);
    rx_in = 1'b1;
    idle(CPB / 2);
    uart_rst_n = 1'b0;
    idle(3);
    chk("midrst_data", int'(rx_data), 0);
    chk("midrst_flags", int'({rx_valid, rx_frame_err, rx_parity_err, rx_overrun}), 0);
    chk("midrst_state", int'(dut.state_q), int'(IDLE));
    uart_rst_n = 1'b1;
    idle(2 * CPB);
    push(K_DATA, 8'h5A);
    send_frame(8'h5A, 1'b1, CPB);
    idle(CPB);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: even parity bit must be 1
    push(K_PERR, 8'h00);
    send_raw({1'b1, 1'b0, 8'h07, 1'b0}, 11, CPB);
    idle(CPB);
    push(K_DATA, 8'h07);
    send_frame(8'h07, 1'b1, CPB);
    idle(CPB);
`endif

    for (int i = 0; i < 2000 && sb.size() != 0; i++) begin
      @(posedge uart_clk);
    end
    idle(2);
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

UART receiver that consumes the serial line driven by the team's UART transmit path. Oversamples at 16× the configured baud rate from a single system clock. Recovers 8N1 frames (optional even parity), flags framing, parity and overrun errors, and holds each received byte in a one-entry output buffer under a valid/ready handshake for the downstream consumer.

## Interface
- `clk_rate`, default 100_000_000: system clock frequency in Hz.
- `baud_rate`, default 9600: line bit rate. `OSR_DIV = clk_rate / (baud_rate * 16)` is integer-truncated and must be ≥ 1.
- `uart_clk`, input, 1: system clock. All logic runs on its rising edge.
- `uart_rst_n`, input, 1: asynchronous, active-low reset. Deassertion is synchronous to `uart_clk` at system level.
- `rx_in`, input, 1: serial line, asynchronous, idle high.
- `rx_ready`, input, 1: consumer accepts the byte when high while `rx_valid` is high.
- `rx_data`, output, 8: received byte, LSB received first.
- `rx_valid`, output, 1: `rx_data` holds an unconsumed byte.
- `rx_frame_err`, output, 1: one-cycle pulse when the stop bit is sampled low.
- `rx_parity_err`, output, 1: one-cycle pulse on parity mismatch. Tied to 0 without the macro.
- `rx_overrun`, output, 1: one-cycle pulse when a good byte completes while the buffer is full.

## Operation
- `rx_in` passes through a 2-flop synchronizer. Both flops reset to 1.
- Oversample tick: a counter runs 0..OSR_DIV-1 and `tick` is high for one cycle when the count equals OSR_DIV-1. The counter clears to 0 on the cycle a start edge is detected.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP. Reset state is IDLE.
  - IDLE: when the synchronized line is 0, clear the tick counter and the 4-bit sample counter, then go to START.
  - START: on the 8th tick (mid-bit), sample the line. If 1, it is a false start: go to IDLE with no output. If 0, go to DATA.
  - DATA: every 16th tick, sample one bit and shift it right into the shift register (MSB in). After 8 bits, go to PARITY or STOP.
  - PARITY: on the 16th tick, sample the bit and compare with the XOR of the 8 data bits (even parity).
  - STOP: on the 16th tick, sample the line and go to IDLE on the same cycle. IDLE is entered at stop mid-bit so back-to-back frames are accepted.
- Frame completion, evaluated in priority order on the cycle after the stop sample:
  - Stop sampled 0: pulse `rx_frame_err` and drop the byte.
  - Otherwise, parity mismatch: pulse `rx_parity_err` and drop the byte.
  - Otherwise, buffer empty, or buffer being consumed this same cycle: load `rx_data` and set `rx_valid`.
  - Otherwise (buffer full and not consumed): pulse `rx_overrun`, drop the new byte, and keep the old byte.
- Handshake: `rx_valid` clears on the cycle after `rx_valid && rx_ready`. `rx_data` is stable while `rx_valid` is high.
- Reset mid-frame: the FSM goes to IDLE, all outputs clear, and the partial byte is discarded.

## Timing
- Reset values: `rx_data`=0x00 and `rx_valid`, `rx_frame_err`, `rx_parity_err`, `rx_overrun` all 0.
- Start detection: 2 cycles of synchronizer latency after `rx_in` falls.
- Samples land at the centre of each bit: 8 ticks after start detection, then every 16 ticks.
- `rx_valid` rises 1 cycle after the stop-bit sample, i.e. about 9.5 bit times after the start edge (10.5 with parity), plus 2 cycles.
- Error pulses occur on the same cycle `rx_valid` would have risen, and last exactly 1 cycle.
- Counter widths: tick counter `$clog2(OSR_DIV+1)` bits, sample counter 4 bits, bit index 3 bits.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state exists, each frame is 11 bits with even parity, and `rx_parity_err` is driven.
- `UART_RX_PARITY_EN` undefined: the PARITY state and its logic are removed, frames are 8N1, and `rx_parity_err` is constant 0.

## Structure
- Package `uart_pkg`:
  - FSM state enum.
  - `UART_DATA_BITS` = 8.
  - `UART_OSR` = 16.
  - `UART_START_MID` = 7.
- Sub-module `uart_os_tick`: parameterized by `clk_rate`/`baud_rate`, with a synchronous clear input and a one-cycle `tick` output.

## Test plan
Bench configuration: `clk_rate`=6_400_000 and `baud_rate`=100_000, giving OSR_DIV=4 and 64 cycles per bit.
1. Send frame 0xA5 with `rx_ready`=1 -> `rx_valid` high for 1 cycle, `rx_data`=0xA5, no error pulses.
2. Send 0x3C with the stop bit driven 0 -> `rx_frame_err` pulses once, `rx_valid` stays 0, and the next frame 0x3C is received correctly.
3. Drive a 16-cycle low glitch on an idle line -> no outputs, FSM back in IDLE, and a following 0x81 is received correctly.
4. Hold `rx_ready`=0 and send 0x11 then 0x22 back-to-back -> `rx_valid` stays high with 0x11 and `rx_overrun` pulses at the end of 0x22. Then raise `rx_ready` -> `rx_valid` falls on the next cycle.
5. Assert `uart_rst_n`=0 in the middle of bit 4 of 0xF0 -> all outputs are 0. Release, send 0x5A -> `rx_data`=0x5A.
6. With `UART_RX_PARITY_EN` defined: send 0x07 with parity bit 0 -> `rx_parity_err` pulses and there is no `rx_valid`. Send 0x07 with parity bit 1 -> `rx_data`=0x07 and `rx_valid` pulses.
